// File: rtl/vend_pkg.sv
// Shared definitions for the vending change controller: coin values, one-hot
// coin codes, FSM state encoding, default prices and the greedy coin picker.
package vend_pkg;

    localparam logic [7:0] COIN_VAL_50 = 8'd50;
    localparam logic [7:0] COIN_VAL_20 = 8'd20;
    localparam logic [7:0] COIN_VAL_10 = 8'd10;
    localparam logic [7:0] COIN_VAL_5  = 8'd5;

    localparam logic [3:0] COIN_OH_50 = 4'b1000;
    localparam logic [3:0] COIN_OH_20 = 4'b0100;
    localparam logic [3:0] COIN_OH_10 = 4'b0010;
    localparam logic [3:0] COIN_OH_5  = 4'b0001;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CHECK    = 3'd1;
    localparam logic [2:0] ST_DISPENSE = 3'd2;
    localparam logic [2:0] ST_CHANGE   = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam int PRICE0_DEF   = 15;
    localparam int PRICE1_DEF   = 25;
    localparam int PRICE2_DEF   = 40;
    localparam int PRICE3_DEF   = 60;
    localparam int COIN_GAP_DEF = 4;

    typedef struct packed {
        logic [3:0] onehot;
        logic [7:0] value;
    } coin_t;

    // Largest coin not exceeding rem; all-zero when rem is below the smallest coin.
    function automatic coin_t greedy_pick(input logic [7:0] rem);
        coin_t c;
        c.onehot = 4'b0000;
        c.value  = 8'd0;
        if (rem >= COIN_VAL_50) begin
            c.onehot = COIN_OH_50;
            c.value  = COIN_VAL_50;
        end else if (rem >= COIN_VAL_20) begin
            c.onehot = COIN_OH_20;
            c.value  = COIN_VAL_20;
        end else if (rem >= COIN_VAL_10) begin
            c.onehot = COIN_OH_10;
            c.value  = COIN_VAL_10;
        end else if (rem >= COIN_VAL_5) begin
            c.onehot = COIN_OH_5;
            c.value  = COIN_VAL_5;
        end
        return c;
    endfunction

endpackage

// File: rtl/vend_change_ctrl_if.sv
// Bus between the coin-accumulation stage / front panel and the change controller.
interface vend_change_ctrl_if;
    // No back-pressure anywhere: buy, cancel, dispense, coin_valid, credit_clr and
    // err_short are single-cycle strobes; credit/item_sel are qualified by buy (and
    // credit_valid), item_out by dispense, coin_out by coin_valid.
    logic [7:0] credit;
    logic       credit_valid;
    logic [1:0] item_sel;
    logic       buy;
    logic       cancel;
    logic       busy;
    logic       dispense;
    logic [1:0] item_out;
    logic [3:0] coin_out;
    logic       coin_valid;
    logic       credit_clr;
    logic       err_short;
    logic [2:0] state_dbg;

    modport master (
        output credit, credit_valid, item_sel, buy, cancel,
        input  busy, dispense, item_out, coin_out, coin_valid, credit_clr, err_short, state_dbg
    );

    modport slave (
        input  credit, credit_valid, item_sel, buy, cancel,
        output busy, dispense, item_out, coin_out, coin_valid, credit_clr, err_short, state_dbg
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change emitter: loaded with an amount on start, emits one coin every
// COIN_GAP cycles largest-first, then flags done or a sub-5 residue.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int COIN_GAP = COIN_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] load_val,
    output logic [3:0] coin_out,
    output logic       coin_valid,
    output logic       done,
    output logic       residue_err
);
    localparam logic [7:0] GAP_RELOAD = 8'(COIN_GAP - 1);

    logic       active_r;
    logic [7:0] rem_r;
    logic [7:0] gap_r;
    logic       ready;
    coin_t      pick;

    assign pick        = greedy_pick(rem_r);
    assign ready       = active_r && (gap_r == 8'd0);
    assign coin_valid  = ready && (pick.value != 8'd0);
    assign coin_out    = coin_valid ? pick.onehot : 4'b0000;
    assign done        = ready && (rem_r == 8'd0);
    assign residue_err = ready && (rem_r != 8'd0) && (pick.value == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= 1'b0;
            rem_r    <= 8'd0;
            gap_r    <= 8'd0;
        end else if (start) begin
            active_r <= 1'b1;
            rem_r    <= load_val;
            gap_r    <= 8'd0;
        end else if (active_r) begin
            if (gap_r != 8'd0) begin
                gap_r <= gap_r - 8'd1;
            end else if (coin_valid) begin
                rem_r <= rem_r - pick.value;
                gap_r <= GAP_RELOAD;
            end else begin
                // done or residue: stream finished, residue discarded
                active_r <= 1'b0;
                rem_r    <= 8'd0;
            end
        end
    end
endmodule

// File: rtl/vend_change_ctrl.sv
// Vending transaction controller: price check, dispense, change return, credit clear.
// Optional refund-on-cancel path enabled by defining VEND_REFUND_EN.
module vend_change_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE0   = PRICE0_DEF,
    parameter int PRICE1   = PRICE1_DEF,
    parameter int PRICE2   = PRICE2_DEF,
    parameter int PRICE3   = PRICE3_DEF,
    parameter int COIN_GAP = COIN_GAP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    vend_change_ctrl_if.slave  bus
);
    logic [2:0] state_r, state_nxt;
    logic [7:0] cred_r, price_r, chg_r;
    logic [1:0] item_r;
    logic       short_c, buy_go, refund_go;
    logic       disp_start, disp_done, disp_err, disp_valid;
    logic [7:0] disp_load;
    logic [3:0] disp_coin;

    function automatic logic [7:0] price_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'(PRICE0);
            2'd1:    return 8'(PRICE1);
            2'd2:    return 8'(PRICE2);
            default: return 8'(PRICE3);
        endcase
    endfunction

`ifdef VEND_REFUND_EN
    assign refund_go = (state_r == ST_IDLE) && bus.cancel && bus.credit_valid && (bus.credit != 8'd0);
`else
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
    assign refund_go     = 1'b0;
`endif

    // cancel outranks buy when both arrive together
    assign buy_go  = (state_r == ST_IDLE) && bus.buy && bus.credit_valid && !refund_go;
    assign short_c = cred_r < price_r;

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE:     if (refund_go) state_nxt = ST_CHANGE;
                         else if (buy_go) state_nxt = ST_CHECK;
            ST_CHECK:    state_nxt = short_c ? ST_IDLE : ST_DISPENSE;
            ST_DISPENSE: state_nxt = (chg_r != 8'd0) ? ST_CHANGE : ST_DONE;
            ST_CHANGE:   if (disp_done || disp_err) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cred_r  <= 8'd0;
            price_r <= 8'd0;
            chg_r   <= 8'd0;
            item_r  <= 2'd0;
        end else begin
            state_r <= state_nxt;
            if (buy_go) begin
                cred_r  <= bus.credit;
                price_r <= price_of(bus.item_sel);
                item_r  <= bus.item_sel;
            end
            if ((state_r == ST_CHECK) && !short_c)
                chg_r <= cred_r - price_r;
        end
    end

    assign disp_start = refund_go || ((state_r == ST_DISPENSE) && (chg_r != 8'd0));
    assign disp_load  = (state_r == ST_IDLE) ? bus.credit : chg_r;

    change_dispenser #(.COIN_GAP(COIN_GAP)) u_disp (
        .clk         (clk),
        .rst         (rst),
        .start       (disp_start),
        .load_val    (disp_load),
        .coin_out    (disp_coin),
        .coin_valid  (disp_valid),
        .done        (disp_done),
        .residue_err (disp_err)
    );

    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.dispense   = (state_r == ST_DISPENSE);
    assign bus.item_out   = (state_r == ST_DISPENSE) ? item_r : 2'd0;
    assign bus.coin_out   = disp_coin;
    assign bus.coin_valid = disp_valid;
    assign bus.credit_clr = (state_r == ST_DONE);
    assign bus.err_short  = ((state_r == ST_CHECK) && short_c) || disp_err;
    assign bus.state_dbg  = state_r;
endmodule

// File: tb/tb_vend_change_ctrl.sv
// Bench for vend_change_ctrl: vector table plus hand sequences, scoreboard of
// timed output events. Honours VEND_REFUND_EN the same way as the design.
module tb_vend_change_ctrl;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_change_ctrl_if bus();
    vend_change_ctrl #(.COIN_GAP(G)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [7:0] credit;
        logic [1:0] item;
        logic       cancel;
        logic       cv;
        int         exp_disp;
        int         exp_coins;
    } vec_t;

    vec_t tbl[12];
    int   prices[4] = '{15, 25, 40, 60};
    int   n_vec = 0, n_bad = 0;
    int   cyc = 0, t0 = 0;
    int   n_disp_seen = 0, n_coin_seen = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ev(input int off, input int typ, input int data);
        return 16'((off << 8) | (typ << 4) | data);
    endfunction

    task automatic observe(input logic [15:0] e);
        logic [15:0] x;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL event: actual=%0h required=none (t=%0t)", e, $time);
        end else begin
            x = exp_q.pop_front();
            check("event", int'(e), int'(x));
        end
    endtask

    // event types: 1 dispense(item), 2 coin(onehot), 3 credit_clr, 4 err_short
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dispense)   begin n_disp_seen++; observe(ev(cyc - t0, 1, int'(bus.item_out))); end
            if (bus.coin_valid) begin n_coin_seen++; observe(ev(cyc - t0, 2, int'(bus.coin_out))); end
            if (bus.credit_clr) observe(ev(cyc - t0, 3, 0));
            if (bus.err_short)  observe(ev(cyc - t0, 4, 0));
        end
    end

    function automatic void push_coins(input int start_t, input int amount);
        int t = start_t;
        int chg = amount;
        int v, oh;
        while (chg >= 5) begin
            if (chg >= 50)      begin v = 50; oh = 8; end
            else if (chg >= 20) begin v = 20; oh = 4; end
            else if (chg >= 10) begin v = 10; oh = 2; end
            else                begin v = 5;  oh = 1; end
            exp_q.push_back(ev(t, 2, oh));
            chg -= v;
            t += G;
        end
        if (chg != 0) exp_q.push_back(ev(t, 4, 0));
        exp_q.push_back(ev(t + 1, 3, 0));
    endfunction

    // Offsets are cycles after the cycle in which buy/cancel is presented.
    function automatic logic expect_txn(input int credit, input int item, input logic cancel, input logic cv);
        if (!cv) return 1'b0;
`ifdef VEND_REFUND_EN
        if (cancel && credit != 0) begin
            push_coins(1, credit);
            return 1'b0;
        end
`endif
        if (credit < prices[item]) begin
            exp_q.push_back(ev(1, 4, 0));
            return 1'b1;
        end
        exp_q.push_back(ev(2, 1, item));
        if (credit == prices[item]) exp_q.push_back(ev(3, 3, 0));
        else push_coins(3, credit - prices[item]);
        return 1'b0;
    endfunction

    task automatic start_txn(input logic [7:0] credit, input logic [1:0] item, input logic cancel, input logic cv);
        @(posedge clk); #1;
        t0 = cyc;
        n_disp_seen = 0;
        n_coin_seen = 0;
        bus.credit = credit;
        bus.item_sel = item;
        bus.cancel = cancel;
        bus.buy = 1'b1;
        bus.credit_valid = cv;
        @(posedge clk); #1;
        bus.buy = 1'b0;
        bus.cancel = 1'b0;
        bus.credit = 8'($urandom_range(0, 255));
        bus.credit_valid = 1'b1;
    endtask

    task automatic finish_txn(input string tag);
        repeat (35) @(posedge clk);
        #1;
        check({tag, "_missing_events"}, exp_q.size(), 0);
        check({tag, "_busy_idle"}, int'(bus.busy), 0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sh;
        tbl[0]  = '{8'd25,  2'd1, 1'b0, 1'b1, 1, 0};
        tbl[1]  = '{8'd100, 2'd0, 1'b0, 1'b1, 1, 4};
        tbl[2]  = '{8'd30,  2'd2, 1'b0, 1'b1, 0, 0};
        tbl[3]  = '{8'd255, 2'd0, 1'b0, 1'b1, 1, 6};
        tbl[4]  = '{8'd60,  2'd3, 1'b0, 1'b1, 1, 0};
        tbl[5]  = '{8'd27,  2'd0, 1'b0, 1'b1, 1, 1};
        tbl[6]  = '{8'd20,  2'd0, 1'b0, 1'b0, 0, 0};
        tbl[7]  = '{8'd59,  2'd3, 1'b0, 1'b1, 0, 0};
`ifdef VEND_REFUND_EN
        tbl[8]  = '{8'd35,  2'd1, 1'b1, 1'b1, 0, 3};
`else
        tbl[8]  = '{8'd35,  2'd1, 1'b1, 1'b1, 1, 1};
`endif
        tbl[9]  = '{8'd80,  2'd2, 1'b0, 1'b1, 1, 2};
        tbl[10] = '{8'd0,   2'd0, 1'b1, 1'b1, 0, 0};
        tbl[11] = '{8'd45,  2'd1, 1'b0, 1'b1, 1, 1};

        rst = 1'b1;
        bus.credit = 8'd0;
        bus.credit_valid = 1'b0;
        bus.item_sel = 2'd0;
        bus.buy = 1'b0;
        bus.cancel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({bus.busy, bus.dispense, bus.item_out, bus.coin_out,
                                     bus.coin_valid, bus.credit_clr, bus.err_short}), 0);
        check("reset_state", int'(bus.state_dbg), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            sh = expect_txn(tbl[i].credit, tbl[i].item, tbl[i].cancel, tbl[i].cv);
            start_txn(tbl[i].credit, tbl[i].item, tbl[i].cancel, tbl[i].cv);
            if (sh) begin
                @(posedge clk);
                @(negedge clk);
                check("busy_after_short", int'(bus.busy), 0);
            end
            finish_txn($sformatf("vec%0d", i));
            check($sformatf("vec%0d_dispense_count", i), n_disp_seen, tbl[i].exp_disp);
            check($sformatf("vec%0d_coin_count", i), n_coin_seen, tbl[i].exp_coins);
        end

        // buy/cancel pulsed mid-stream with a new credit: stream must be untouched
        sh = expect_txn(100, 0, 1'b0, 1'b1);
        start_txn(8'd100, 2'd0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.credit = 8'd200;
        bus.item_sel = 2'd3;
        bus.buy = 1'b1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.buy = 1'b0;
        bus.cancel = 1'b0;
        finish_txn("busy_ignore");
        check("busy_ignore_coin_count", n_coin_seen, 4);

        // reset right after the 2nd coin of a 4-coin return
        @(posedge clk); #1;
        exp_q.push_back(ev(2, 1, 0));
        exp_q.push_back(ev(3, 2, 8));
        exp_q.push_back(ev(3 + G, 2, 4));
        start_txn(8'd100, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        check("reset_seq_reached_coin2", exp_q.size(), 0);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_outputs", int'({bus.busy, bus.dispense, bus.item_out, bus.coin_out,
                                        bus.coin_valid, bus.credit_clr, bus.err_short}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_coin_seen = 0;
        repeat (30) @(posedge clk);
        #1;
        check("midreset_no_more_coins", n_coin_seen, 0);
        check("midreset_busy", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
